// File: rtl/ripple_add_seq.sv
// ripple_add_seq: multi-cycle ripple-carry adder, CHUNK bits per clock with a registered carry.
// Define RIPPLE_ADD_OVF_EN to add the signed-overflow output ovf.
module ripple_add_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RIPPLE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("ripple_add_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] slice_d;
  logic             carry_d;

  always_comb begin
    a_sl = a_q[32'(idx_q) * CHUNK +: CHUNK];
    b_sl = b_q[32'(idx_q) * CHUNK +: CHUNK];
    {carry_d, slice_d} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
  end

`ifdef RIPPLE_ADD_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin_msb.
  always_comb begin
    ovf_d = (a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ slice_d[CHUNK-1]) ^ carry_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == BUSY && idx_q == LAST_IDX) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          sum_q[32'(idx_q) * CHUNK +: CHUNK] <= slice_d;
          carry_q <= carry_d;
          if (idx_q == LAST_IDX) begin
            cout_q      <= carry_d;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
